// File: rtl/booth_operand_loader_pkg.sv
// Shared definitions for the Booth operand path: default widths and the phase
// encodings seen by the Booth core and the display logic.
package booth_operand_loader_pkg;

  localparam int W_DEF          = 4;
  localparam int DROP_CNT_W_DEF = 4;

  localparam logic [1:0] PH_WAIT_A    = 2'd0;
  localparam logic [1:0] PH_WAIT_B    = 2'd1;
  localparam logic [1:0] PH_ISSUE     = 2'd2;
  localparam logic [1:0] PH_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT_A    = PH_WAIT_A,
    ST_WAIT_B    = PH_WAIT_B,
    ST_ISSUE     = PH_ISSUE,
    ST_WAIT_DONE = PH_WAIT_DONE
  } state_e;

endpackage

// File: rtl/booth_operand_loader_edge_rise.sv
// Registered rising-edge detector: one history flop, rise = d & ~d_q.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/booth_operand_loader.sv
// Captures two pushbutton entries as Booth operands A and B, offers them to the
// core over valid/ready and holds off new entries until the core signals done.
module booth_operand_loader
  import booth_operand_loader_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [W-1:0]          count,
  input  logic                  valid,
  input  logic                  op_ready,
  input  logic                  done,
  output logic                  op_valid,
  output logic [W-1:0]          op_a,
  output logic [W-1:0]          op_b,
  output logic                  busy,
  output logic [1:0]            phase,
  output logic [DROP_CNT_W-1:0] dropped
);

  state_e                state_q, state_d;
  logic [W-1:0]          op_a_q, op_a_d;
  logic [W-1:0]          op_b_q, op_b_d;
  logic                  op_valid_q, op_valid_d;
  logic                  busy_q, busy_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;
  logic                  entry_evt;

  edge_rise u_valid_rise (
    .clk  (CLK),
    .rst  (rst),
    .d    (valid),
    .rise (entry_evt)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_WAIT_A: begin
        if (entry_evt) begin
          op_a_d  = count;
          state_d = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (entry_evt) begin
          op_b_d  = count;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_valid_q && op_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (done) begin
          state_d = ST_WAIT_A;
        end
      end
      default: state_d = ST_WAIT_A;
    endcase
    // Entries arriving while an operand pair is in flight are counted, never captured.
    if (entry_evt && (state_q == ST_ISSUE || state_q == ST_WAIT_DONE) && !(&dropped_q)) begin
      dropped_d = dropped_q + DROP_CNT_W'(1);
    end
    op_valid_d = (state_d == ST_ISSUE);
    busy_d     = (state_d == ST_WAIT_DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_WAIT_A;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign busy     = busy_q;
  assign phase    = state_q;
  assign dropped  = dropped_q;

endmodule
